// File: rtl/dpram_be_clr.sv
// True dual-port synchronous RAM with per-lane write enables, selectable
// read-during-write behaviour and an optional post-reset fill sequence.
`timescale 1ns/1ps
module dpram_be_clr #(
    parameter int                    ADDR_WIDTH     = 12,
    parameter int                    DATA_WIDTH     = 8,
    parameter int                    LANES          = 1,
    parameter bit                    RDW_MODE       = 1'b0,
    parameter bit                    CLEAR_ON_RESET = 1'b1,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE    = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic                  busy,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    input  logic [DATA_WIDTH-1:0] a_din,
    input  logic [LANES-1:0]      a_be,
    input  logic                  a_rd_n,
    input  logic                  a_wr_n,
    input  logic                  a_ce_n,
    output logic [DATA_WIDTH-1:0] a_q,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    input  logic [DATA_WIDTH-1:0] b_din,
    input  logic [LANES-1:0]      b_be,
    input  logic                  b_rd_n,
    input  logic                  b_wr_n,
    input  logic                  b_ce_n,
    output logic [DATA_WIDTH-1:0] b_q
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int LW    = DATA_WIDTH / LANES;

    typedef enum logic {S_CLEAR, S_READY} state_t;

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   cnt;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];
    logic [DATA_WIDTH-1:0]   a_data, b_data;
    logic [DATA_WIDTH-1:0]   a_fwd, b_fwd, a_rd_word, b_rd_word;
    logic                    a_we, b_we, a_re, b_re;

    function automatic logic [DATA_WIDTH-1:0] merge_lanes(
        input logic [DATA_WIDTH-1:0] old_word,
        input logic [DATA_WIDTH-1:0] din,
        input logic [LANES-1:0]      be
    );
        logic [DATA_WIDTH-1:0] w;
        w = old_word;
        for (int l = 0; l < LANES; l++)
            if (be[l]) w[l*LW +: LW] = din[l*LW +: LW];
        return w;
    endfunction

    assign a_we = !a_wr_n && !a_ce_n && (state == S_READY);
    assign b_we = !b_wr_n && !b_ce_n && (state == S_READY);
    assign a_re = !a_rd_n && !a_ce_n;
    assign b_re = !b_rd_n && !b_ce_n;

    // Final word at each port's address after this edge's writes (B first, A on top)
    always_comb begin
        a_fwd = mem[a_addr];
        if (b_we && (b_addr == a_addr)) a_fwd = merge_lanes(a_fwd, b_din, b_be);
        if (a_we)                       a_fwd = merge_lanes(a_fwd, a_din, a_be);
        b_fwd = mem[b_addr];
        if (b_we)                       b_fwd = merge_lanes(b_fwd, b_din, b_be);
        if (a_we && (a_addr == b_addr)) b_fwd = merge_lanes(b_fwd, a_din, a_be);
    end

    assign a_rd_word = RDW_MODE ? a_fwd : mem[a_addr];
    assign b_rd_word = RDW_MODE ? b_fwd : mem[b_addr];

    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state == S_CLEAR) begin
                mem[cnt] <= CLEAR_VALUE;
            end else begin
                for (int l = 0; l < LANES; l++)
                    if (b_we && b_be[l]) mem[b_addr][l*LW +: LW] <= b_din[l*LW +: LW];
                // Port A is assigned last so it owns any lane both ports write
                for (int l = 0; l < LANES; l++)
                    if (a_we && a_be[l]) mem[a_addr][l*LW +: LW] <= a_din[l*LW +: LW];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= CLEAR_ON_RESET ? S_CLEAR : S_READY;
            cnt    <= '0;
            busy   <= CLEAR_ON_RESET;
            a_data <= '0;
            b_data <= '0;
        end else begin
            case (state)
                S_CLEAR: begin
                    cnt <= cnt + 1'b1;
                    if (&cnt) begin
                        state <= S_READY;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    if (a_re) a_data <= a_rd_word;
                    if (b_re) b_data <= b_rd_word;
                end
            endcase
        end
    end

    assign a_q = a_ce_n ? '0 : a_data;
    assign b_q = b_ce_n ? '0 : b_data;

endmodule

// File: tb/tb_dpram_be_clr.sv
// Scoreboard bench for dpram_be_clr: two instances (read-old and write-first)
// share stimulus and are checked against an array model of the memory.
`timescale 1ns/1ps
module tb_dpram_be_clr;
    localparam int             AW    = 4;
    localparam int             DW    = 16;
    localparam int             LN    = 2;
    localparam int             DEPTH = 16;
    localparam logic [DW-1:0]  CLR   = 16'hA5C3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic [AW-1:0] a_addr, b_addr;
    logic [DW-1:0] a_din, b_din;
    logic [LN-1:0] a_be, b_be;
    logic          a_rd_n, a_wr_n, a_ce_n, b_rd_n, b_wr_n, b_ce_n;
    logic          busy0, busy1;
    logic [DW-1:0] a_q0, b_q0, a_q1, b_q1;

    dpram_be_clr #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LANES(LN), .RDW_MODE(1'b0),
                   .CLEAR_ON_RESET(1'b1), .CLEAR_VALUE(CLR)) u_dut0 (
        .clk(clk), .reset(reset), .busy(busy0),
        .a_addr(a_addr), .a_din(a_din), .a_be(a_be), .a_rd_n(a_rd_n), .a_wr_n(a_wr_n),
        .a_ce_n(a_ce_n), .a_q(a_q0),
        .b_addr(b_addr), .b_din(b_din), .b_be(b_be), .b_rd_n(b_rd_n), .b_wr_n(b_wr_n),
        .b_ce_n(b_ce_n), .b_q(b_q0));

    dpram_be_clr #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LANES(LN), .RDW_MODE(1'b1),
                   .CLEAR_ON_RESET(1'b1), .CLEAR_VALUE(CLR)) u_dut1 (
        .clk(clk), .reset(reset), .busy(busy1),
        .a_addr(a_addr), .a_din(a_din), .a_be(a_be), .a_rd_n(a_rd_n), .a_wr_n(a_wr_n),
        .a_ce_n(a_ce_n), .a_q(a_q1),
        .b_addr(b_addr), .b_din(b_din), .b_be(b_be), .b_rd_n(b_rd_n), .b_wr_n(b_wr_n),
        .b_ce_n(b_ce_n), .b_q(b_q1));

    typedef struct packed {
        logic [DW-1:0] old_w;
        logic [DW-1:0] new_w;
    } exp_t;

    exp_t          qa[$], qb[$];
    exp_t          ea, eb;
    logic [DW-1:0] mem_m [DEPTH];
    int            clr_left = 0;
    int            checks = 0;
    int            passed = 0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [DW-1:0] put(input logic [DW-1:0] w, input logic [DW-1:0] din,
                                          input logic [LN-1:0] en);
        logic [DW-1:0] r;
        r = w;
        for (int l = 0; l < LN; l++)
            if (en[l]) r[l*8 +: 8] = din[l*8 +: 8];
        return r;
    endfunction

    task automatic drv_a(input bit ce, input bit rd, input bit wr, input logic [AW-1:0] addr,
                         input logic [DW-1:0] din, input logic [LN-1:0] be);
        a_ce_n = !ce; a_rd_n = !rd; a_wr_n = !wr;
        a_addr = ce ? addr : 'x;
        a_din  = ce ? din  : 'x;
        a_be   = ce ? be   : 'x;
    endtask

    task automatic drv_b(input bit ce, input bit rd, input bit wr, input logic [AW-1:0] addr,
                         input logic [DW-1:0] din, input logic [LN-1:0] be);
        b_ce_n = !ce; b_rd_n = !rd; b_wr_n = !wr;
        b_addr = ce ? addr : 'x;
        b_din  = ce ? din  : 'x;
        b_be   = ce ? be   : 'x;
    endtask

    task automatic idle();
        drv_a(0, 0, 0, '0, '0, '0);
        drv_b(0, 0, 0, '0, '0, '0);
    endtask

    // One clock: the model applies the rules for this edge and queues read results
    task automatic step();
        logic          a_r, b_r, a_w, b_w;
        logic [LN-1:0] b_mask;
        logic [DW-1:0] old_a, old_b;
        @(posedge clk);
        a_r = !a_ce_n && !a_rd_n;  a_w = !a_ce_n && !a_wr_n;
        b_r = !b_ce_n && !b_rd_n;  b_w = !b_ce_n && !b_wr_n;
        if (reset) begin
            clr_left = DEPTH;
            qa.push_back('0);
            qb.push_back('0);
        end else if (clr_left > 0) begin
            mem_m[DEPTH - clr_left] = CLR;
            clr_left--;
        end else begin
            old_a = a_r ? mem_m[a_addr] : '0;
            old_b = b_r ? mem_m[b_addr] : '0;
            if (b_w) begin
                b_mask = b_be;
                if (a_w && (a_addr == b_addr)) b_mask = b_be & ~a_be;
                mem_m[b_addr] = put(mem_m[b_addr], b_din, b_mask);
            end
            if (a_w) mem_m[a_addr] = put(mem_m[a_addr], a_din, a_be);
            if (a_r) qa.push_back('{old_w: old_a, new_w: mem_m[a_addr]});
            if (b_r) qb.push_back('{old_w: old_b, new_w: mem_m[b_addr]});
        end
        #1;
    endtask

    initial begin
        ea = '0;
        eb = '0;
        forever begin
            @(negedge clk);
            while (qa.size() > 0) ea = qa.pop_front();
            while (qb.size() > 0) eb = qb.pop_front();
            check("a_q_rdw0", a_q0, a_ce_n ? '0 : ea.old_w);
            check("a_q_rdw1", a_q1, a_ce_n ? '0 : ea.new_w);
            check("b_q_rdw0", b_q0, b_ce_n ? '0 : eb.old_w);
            check("b_q_rdw1", b_q1, b_ce_n ? '0 : eb.new_w);
            check("busy", {{(DW-2){1'b0}}, busy1, busy0}, {{(DW-2){1'b0}}, {2{clr_left > 0}}});
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit, got running expected finished");
        $fatal(1);
    end

    initial begin
        logic [AW-1:0] ra, rb;
        for (int i = 0; i < DEPTH; i++) mem_m[i] = 'x;
        idle();
        reset = 1'b1;
        step();
        reset = 1'b0;

        // write attempts on both ports throughout the fill must be dropped
        for (int i = 0; i < DEPTH; i++) begin
            drv_a(1, 1, 1, AW'(i), DW'($urandom), 2'b11);
            drv_b(1, 1, 1, AW'(DEPTH - 1 - i), DW'($urandom), 2'b11);
            step();
        end

        for (int i = 0; i < DEPTH; i++) begin
            drv_a(1, 1, 0, AW'(i), '0, '0);
            drv_b(1, 1, 0, AW'(DEPTH - 1 - i), '0, '0);
            step();
        end
        idle();
        step();

        // reset while the fill counter sits at 7
        reset = 1'b1; step(); reset = 1'b0;
        repeat (7) step();
        reset = 1'b1; step(); reset = 1'b0;
        repeat (DEPTH) step();
        step();

        drv_a(1, 0, 1, 4'd3, 16'h1234, 2'b11); step();
        drv_a(1, 0, 1, 4'd3, 16'hABCD, 2'b01); step();
        drv_a(1, 1, 0, 4'd3, '0, '0);          step();
        @(negedge clk);
        check("lane_merge0", a_q0, 16'h12CD);
        check("lane_merge1", a_q1, 16'h12CD);

        drv_a(1, 0, 1, 4'd5, 16'h7788, 2'b11); step();
        drv_a(1, 0, 1, 4'd5, 16'h1111, 2'b01);
        drv_b(1, 1, 1, 4'd5, 16'h2222, 2'b11); step();
        @(negedge clk);
        check("collide_rd_old", b_q0, 16'h7788);
        check("collide_rd_new", b_q1, 16'h2211);
        drv_a(0, 0, 0, '0, '0, '0);
        drv_b(1, 1, 0, 4'd5, '0, '0); step();
        @(negedge clk);
        check("collide_stored", b_q0, 16'h2211);

        drv_b(0, 0, 0, '0, '0, '0);
        drv_a(1, 0, 1, 4'd2, 16'h005A, 2'b11); step();
        drv_a(1, 1, 0, 4'd2, '0, '0);          step();
        a_ce_n = 1'b1; #1;
        check("ce_gate_off", a_q0, 16'h0000);
        a_ce_n = 1'b0; a_rd_n = 1'b1; #1;
        check("ce_gate_hold", a_q0, 16'h005A);
        step();
        a_ce_n = 1'b1; a_wr_n = 1'b0; a_addr = 4'd2; a_din = 16'hFFFF; a_be = 2'b11; step();
        drv_a(1, 1, 0, 4'd2, '0, '0); step();
        @(negedge clk);
        check("ce_blocks_write", a_q1, 16'h005A);

        // A writes while B reads a different address every cycle
        for (int i = 0; i < 64; i++) begin
            ra = AW'($urandom);
            rb = AW'($urandom);
            if (rb == ra) rb = ra + 1'b1;
            drv_a(1, 0, 1, ra, DW'($urandom), LN'($urandom));
            drv_b(1, 1, 0, rb, '0, '0);
            step();
        end

        // mixed traffic on a narrow address range to force collisions
        for (int i = 0; i < 300; i++) begin
            drv_a($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                  AW'($urandom_range(0, 3)), DW'($urandom), LN'($urandom));
            drv_b($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                  AW'($urandom_range(0, 3)), DW'($urandom), LN'($urandom));
            step();
        end

        idle();
        step();
        step();
        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
